// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - VRAM pattern fill engine with optional boot-time fill
//
// Writes a generated pattern into a VRAM write port, one word per clock.
// After reset it can fill the whole memory with an incrementing pattern on
// its own.
//
// Ports:
//   clk         memory clock; every register in this block runs on it
//   rst_n       synchronous active-low reset
//   start       one-cycle request to begin a fill (honoured only in IDLE)
//   abort       ends a running fill after the write issued in that cycle
//   mode        pattern: 0 CONST, 1 INCR, 2 ADDR, 3 ALT
//   base_addr   first write address (taken modulo DEPTH)
//   length      word count, clamped to DEPTH
//   fill_value  pattern seed
//   mask        AND-mask applied to every written word
//   we          VRAM write enable (cea)
//   waddr       VRAM write address (ada); holds its value while we=0
//   wdata       VRAM write data (din); holds its value while we=0
//   busy        high while writes are being issued
//   done        one-cycle completion pulse
//   aborted     set together with done when the fill was aborted; held until the next start
module vram_fill_engine #(
  parameter int                ADDR_W        = 10,
  parameter int                DATA_W        = 8,
  parameter int                DEPTH         = 1024,
  parameter bit                BOOT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] BOOT_MASK     = DATA_W'(8'h7F)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] mask,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0]     DEPTH_L   = LW'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic              we_n, busy_n, done_n, aborted_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] wdata_n;

  // Parameters of the running fill, captured when it is accepted.
  logic [1:0]        mode_r, mode_n;
  logic [DATA_W-1:0] fv_r, fv_n;
  logic [DATA_W-1:0] mask_r, mask_n;
  // idx_r is the index of the word currently on the port; left_r counts
  // the words still to be written after it.
  logic [LW-1:0]     idx_r, idx_n;
  logic [LW-1:0]     left_r, left_n;
  // Set by reset when the boot fill is enabled; consumed by the first fill.
  logic              boot_r, boot_n;

  // Request mux: the pending boot fill overrides the external start inputs.
  logic              req;
  logic [1:0]        req_mode;
  logic [ADDR_W-1:0] req_base;
  logic [LW-1:0]     req_len;
  logic [DATA_W-1:0] req_fv;
  logic [DATA_W-1:0] req_mask;
  logic [LW-1:0]     base_mod;
  logic [LW-1:0]     len_clamped;
  logic [ADDR_W-1:0] first_addr;
  logic [LW-1:0]     next_idx;
  logic [ADDR_W-1:0] next_addr;

  function automatic logic [DATA_W-1:0] gen_word(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] fv,
    input logic [DATA_W-1:0] mk,
    input logic [LW-1:0]     i,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    case (m)
      MODE_CONST: d = fv;
      MODE_INCR:  d = fv + DATA_W'(i);
      // Size cast zero-extends or truncates the address to the data width.
      MODE_ADDR:  d = DATA_W'(a);
      default:    d = i[0] ? ~fv : fv;
    endcase
    return d & mk;
  endfunction

  always_comb begin
    req = boot_r | start;
    if (boot_r) begin
      req_mode = MODE_INCR;
      req_base = '0;
      req_len  = DEPTH_L;
      req_fv   = '0;
      req_mask = BOOT_MASK;
    end else begin
      req_mode = mode;
      req_base = base_addr;
      req_len  = length;
      req_fv   = fill_value;
      req_mask = mask;
    end

    // Widened by one bit so the modulus is non-zero when DEPTH = 2^ADDR_W.
    base_mod    = {1'b0, req_base} % DEPTH_L;
    first_addr  = base_mod[ADDR_W-1:0];
    len_clamped = (req_len > DEPTH_L) ? DEPTH_L : req_len;
    next_idx    = idx_r + LW'(1);
    next_addr   = (waddr == LAST_ADDR) ? '0 : waddr + ADDR_W'(1);

    state_n   = state;
    we_n      = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    aborted_n = aborted;
    waddr_n   = waddr;
    wdata_n   = wdata;
    mode_n    = mode_r;
    fv_n      = fv_r;
    mask_n    = mask_r;
    idx_n     = idx_r;
    left_n    = left_r;
    boot_n    = boot_r;

    case (state)
      IDLE: begin
        // abort has no meaning here, so start wins when both are present.
        if (req) begin
          boot_n    = 1'b0;
          aborted_n = 1'b0;
          mode_n    = req_mode;
          fv_n      = req_fv;
          mask_n    = req_mask;
          if (len_clamped == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = WRITE;
            we_n    = 1'b1;
            busy_n  = 1'b1;
            waddr_n = first_addr;
            wdata_n = gen_word(req_mode, req_fv, req_mask, '0, first_addr);
            idx_n   = '0;
            left_n  = len_clamped - LW'(1);
          end
        end
      end

      WRITE: begin
        // The word on the port this cycle is written regardless of abort.
        if (abort) begin
          state_n   = DONE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (left_r == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          we_n    = 1'b1;
          busy_n  = 1'b1;
          idx_n   = next_idx;
          left_n  = left_r - LW'(1);
          waddr_n = next_addr;
          wdata_n = gen_word(mode_r, fv_r, mask_r, next_idx, next_addr);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      mode_r  <= '0;
      fv_r    <= '0;
      mask_r  <= '0;
      idx_r   <= '0;
      left_r  <= '0;
      boot_r  <= BOOT_ON_RESET;
    end else begin
      state   <= state_n;
      we      <= we_n;
      waddr   <= waddr_n;
      wdata   <= wdata_n;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= aborted_n;
      mode_r  <= mode_n;
      fv_r    <= fv_n;
      mask_r  <= mask_n;
      idx_r   <= idx_n;
      left_r  <= left_n;
      boot_r  <= boot_n;
    end
  end

endmodule
